// File: rtl/battle_pkg.sv
// Shared types and widths for the attack resolution datapath.
// Holds the FSM state encoding and the saturating HP subtraction helper.
package battle_pkg;

    localparam int HP_W = 8;
    localparam int MV_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ROLL   = 3'd1,
        S_APPLY  = 3'd2,
        S_REPORT = 3'd3,
        S_OVER   = 3'd4
    } state_t;

    // One extra bit catches the borrow so HP clamps at zero instead of wrapping.
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                                input logic [MV_W-1:0] d);
        logic [HP_W:0] w_diff;
        w_diff = {1'b0, hp} - {{(HP_W+1-MV_W){1'b0}}, d};
        return w_diff[HP_W] ? '0 : w_diff[HP_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr4.sv
// Free-running 4-bit maximal-length LFSR (x^4 + x^3 + 1), values 1..15.
// A zero seed would lock the register, so it is replaced with 4'b0001.
module lfsr4
    import battle_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [MV_W-1:0] seed,
    output logic [MV_W-1:0] q
);

    logic [MV_W-1:0] w_seed;
    logic [MV_W-1:0] r_q;

    assign w_seed = (seed == '0) ? 4'b0001 : seed;
    assign q      = r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= w_seed;
        end else begin
            r_q <= {r_q[2:0], r_q[3] ^ r_q[2]};
        end
    end

endmodule

// File: rtl/attack_resolver.sv
// Resolves one attack per request: roll accuracy, apply clamped damage, report,
// and detect a knock-out. start is taken only while ready=1; nothing is queued.
module attack_resolver
    import battle_pkg::*;
#(
    parameter logic [HP_W-1:0] HP_INIT   = 8'd40,
    parameter logic [MV_W-1:0] LFSR_SEED = 4'b1001
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            attacker,
    input  logic [MV_W-1:0] dmg,
    input  logic [MV_W-1:0] accu,
    input  logic            new_game,
    output logic            ready,
    output logic            done,
    output logic            hit,
    output logic [HP_W-1:0] hp_p1,
    output logic [HP_W-1:0] hp_p2,
    output logic            game_over,
    output logic            winner,
    output state_t          dbg_state
);

    state_t          r_state;
    logic [MV_W-1:0] r_dmg;
    logic [MV_W-1:0] r_accu;
    logic            r_attacker;
    logic [MV_W-1:0] r_rnd;
    logic [HP_W-1:0] r_hp1;
    logic [HP_W-1:0] r_hp2;
    logic            r_ready;
    logic            r_done;
    logic            r_hit;
    logic            r_over;
    logic            r_winner;

    logic [MV_W-1:0] w_lfsr;
    logic [HP_W-1:0] w_def_hp;
    logic            w_hit;
    logic [HP_W-1:0] w_new_hp;

    lfsr4 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    // attacker=0 means player 1 attacks, so player 2 defends.
    assign w_def_hp = r_attacker ? r_hp1 : r_hp2;
    assign w_hit    = (r_rnd <= r_accu);
    assign w_new_hp = w_hit ? sat_sub(w_def_hp, r_dmg) : w_def_hp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dmg      <= '0;
            r_accu     <= '0;
            r_attacker <= 1'b0;
            r_rnd      <= '0;
            r_hp1      <= HP_INIT;
            r_hp2      <= HP_INIT;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
            r_hit      <= 1'b0;
            r_over     <= 1'b0;
            r_winner   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // new_game takes priority; a simultaneous start is dropped.
                    if (new_game) begin
                        r_hp1 <= HP_INIT;
                        r_hp2 <= HP_INIT;
                    end else if (start) begin
                        r_dmg      <= dmg;
                        r_accu     <= accu;
                        r_attacker <= attacker;
                        r_ready    <= 1'b0;
                        r_state    <= S_ROLL;
                    end
                end
                S_ROLL: begin
                    r_rnd   <= w_lfsr;
                    r_state <= S_APPLY;
                end
                S_APPLY: begin
                    if (r_attacker) begin
                        r_hp1 <= w_new_hp;
                    end else begin
                        r_hp2 <= w_new_hp;
                    end
                    r_hit   <= w_hit;
                    r_done  <= 1'b1;
                    r_state <= S_REPORT;
                end
                S_REPORT: begin
                    if (w_def_hp == '0) begin
                        r_over   <= 1'b1;
                        r_winner <= r_attacker;
                        r_state  <= S_OVER;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_OVER: begin
                    if (new_game) begin
                        r_hp1   <= HP_INIT;
                        r_hp2   <= HP_INIT;
                        r_over  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign done      = r_done;
    assign hit       = r_hit;
    assign hp_p1     = r_hp1;
    assign hp_p2     = r_hp2;
    assign game_over = r_over;
    assign winner    = r_winner;
    assign dbg_state = r_state;

endmodule

// File: doc/attack_resolver.md
ATTACK_RESOLVER -- requirements
Module: attack_resolver

Interface
REQ-001 Parameter HP_INIT, default 8'd40, starting HP of each player.
REQ-002 Parameter LFSR_SEED, default 4'b1001, non-zero LFSR reset value; zero SHALL be treated as 4'b0001.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to resolve one attack; accepted only when ready=1.
REQ-006 attacker  input  1  0 = player 1 attacks player 2, 1 = player 2 attacks player 1.
REQ-007 dmg  input  4  damage value from the move-selection stage, sampled at acceptance.
REQ-008 accu  input  4  accuracy value from the move-selection stage, sampled at acceptance.
REQ-009 new_game  input  1  pulse restoring both HP values to HP_INIT.
REQ-010 ready  output  1  high in IDLE only.
REQ-011 done  output  1  one-cycle pulse when an attack result is final.
REQ-012 hit  output  1  result of last accuracy roll; held until next done.
REQ-013 hp_p1  output  8  player 1 HP.
REQ-014 hp_p2  output  8  player 2 HP.
REQ-015 game_over  output  1  high while in OVER.
REQ-016 winner  output  1  0 = player 1 won, 1 = player 2 won; valid while game_over=1.

Function
REQ-017 States SHALL be IDLE, ROLL, APPLY, REPORT, OVER.
REQ-018 IDLE with start=1 SHALL latch dmg, accu, attacker and go to ROLL next cycle.
REQ-019 start while ready=0 SHALL be ignored, with no queuing.
REQ-020 ROLL SHALL capture the current 4-bit LFSR value as rnd and go to APPLY.
REQ-021 LFSR SHALL advance every cycle, polynomial x^4+x^3+1, producing only values 1..15.
REQ-022 hit SHALL equal (rnd <= accu); accu=0 never hits, accu=15 always hits.
REQ-023 APPLY SHALL update the defender HP as max(HP - dmg, 0) on hit, unchanged on miss, then go to REPORT.
REQ-024 Subtraction SHALL use 9-bit intermediate arithmetic; HP SHALL never wrap.
REQ-025 REPORT SHALL assert done for exactly one cycle and update hit.
REQ-026 From REPORT, the FSM SHALL go to OVER if defender HP is 0, else IDLE.
REQ-027 Latency SHALL be start accepted at cycle N, done high at cycle N+3, ready high again at N+4 unless KO.
REQ-028 On entering OVER, winner SHALL equal latched attacker; game_over=1, ready=0.
REQ-029 new_game in IDLE or OVER SHALL load both HP with HP_INIT, clear game_over, and go or stay in IDLE next cycle.
REQ-030 new_game in ROLL, APPLY or REPORT SHALL be ignored.
REQ-031 new_game and start in the same IDLE cycle: new_game SHALL win and start SHALL be dropped.
REQ-032 dmg=0 with hit=1 SHALL leave HP unchanged and still report hit=1.

Reset
REQ-033 rst_n low SHALL immediately force IDLE, hp_p1=hp_p2=HP_INIT, done=0, hit=0, game_over=0, winner=0, LFSR=LFSR_SEED, ready=1 after release.
REQ-034 Reset mid-attack SHALL abort the attack without altering HP beyond the reset values.

Structure
REQ-035 Shared package battle_pkg SHALL hold the state enum, HP width constant (8), and move-value width (4).
REQ-036 The LFSR SHALL be a sub-module lfsr4 (clk, rst_n, seed, q).

Verification
REQ-037 Reset, then start attacker=0 dmg=3 accu=15 -> done at N+3, hit=1, hp_p2=37, hp_p1=40.
REQ-038 start accu=0 dmg=15 -> hit=0, HP unchanged, ready back at N+4.
REQ-039 hp_p1=5, attacker=1, dmg=10 accu=15 -> hp_p1=0, game_over=1, winner=1, ready=0; then new_game -> both HP 40, ready=1.
REQ-040 start held high continuously -> exactly one attack every 4 cycles, no extra acceptances.
REQ-041 Seed 4'b1001, 16 consecutive ROLLs accu=7 -> rnd sequence matches reference model, never 0, hits only when rnd<=7.
REQ-042 rst_n asserted during APPLY -> outputs at reset values in the same cycle, no done pulse.
